// File: rtl/reg_read.sv
// Operand-read (decode) stage of the multi-cycle CPU.
// Owns the register file, takes write-back updates on one port, and on a
// start pulse decodes one instruction and reads its two source registers,
// handing the result to the execute stage as a single operand bundle.
//
// Handshake: out_valid is asserted in OUT and stays high, with every bundle
// field frozen, until a rising clock edge samples out_ready=1 while
// out_valid=1; that edge is the transfer and the stage returns to IDLE.
// out_valid never depends combinationally on out_ready.
module reg_read #(
   parameter int DW = 32,
   parameter int NREG = 32,
   parameter bit ZERO_R0 = 1'b1,
   localparam int AW = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ide,
   input  logic [31:0]   instr,
   input  logic          wb_update,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [5:0]    op,
   output logic [4:0]    rd,
   output logic [4:0]    rt_addr,
   output logic [DW-1:0] rs_val,
   output logic [DW-1:0] rt_val,
   output logic [DW-1:0] imm_ext
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DEC  = 2'd1,
      RD   = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic [5:0]    op_q, op_d;
   logic [4:0]    rd_q, rd_d;
   logic [4:0]    rt_addr_q, rt_addr_d;
   logic [DW-1:0] imm_ext_q, imm_ext_d;
   logic [DW-1:0] rs_val_q, rs_val_d;
   logic [DW-1:0] rt_val_q, rt_val_d;
   logic          out_valid_q, out_valid_d;

   logic [DW-1:0] file_q [NREG];
   logic [DW-1:0] file_d [NREG];

   // Source register addresses come from the latched instruction word.
   logic [AW-1:0] rs_a;
   logic [AW-1:0] rt_a;
   logic [DW-1:0] rs_sel;
   logic [DW-1:0] rt_sel;

   assign rs_a = instr_q[21 +: AW];
   assign rt_a = instr_q[16 +: AW];

   // Register-file update: one write per cycle in any state, r0 optionally hard-wired.
   always_comb begin
      file_d = file_q;
      if (wb_update && !(ZERO_R0 && wb_addr == '0)) begin
         file_d[wb_addr] = wb_data;
      end
   end

   // Register-file storage; reset clears every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            file_q[i] <= '0;
         end
      end else begin
         file_q <= file_d;
      end
   end

   // Read ports with write bypass so a same-cycle write-back is seen by the read.
   always_comb begin
      rs_sel = file_q[rs_a];
      rt_sel = file_q[rt_a];
      if (wb_update && wb_addr == rs_a) begin
         rs_sel = wb_data;
      end
      if (wb_update && wb_addr == rt_a) begin
         rt_sel = wb_data;
      end
      if (ZERO_R0 && rs_a == '0) begin
         rs_sel = '0;
      end
      if (ZERO_R0 && rt_a == '0) begin
         rt_sel = '0;
      end
   end

   // Next-state and datapath: latch, decode, read, then hold until accepted.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rt_addr_d   = rt_addr_q;
      imm_ext_d   = imm_ext_q;
      rs_val_d    = rs_val_q;
      rt_val_d    = rt_val_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (ide) begin
               instr_d = instr;
               state_d = DEC;
            end
         end
         DEC: begin
            op_d      = instr_q[31:26];
            rd_d      = instr_q[15:11];
            rt_addr_d = instr_q[20:16];
            imm_ext_d = {{(DW-16){instr_q[15]}}, instr_q[15:0]};
            state_d   = RD;
         end
         RD: begin
            rs_val_d    = rs_sel;
            rt_val_d    = rt_sel;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            // Bundle fields are not touched here, so they stay frozen during a stall.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // Pipeline-stage registers; reset abandons any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         instr_q     <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         rt_addr_q   <= '0;
         imm_ext_q   <= '0;
         rs_val_q    <= '0;
         rt_val_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rt_addr_q   <= rt_addr_d;
         imm_ext_q   <= imm_ext_d;
         rs_val_q    <= rs_val_d;
         rt_val_q    <= rt_val_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign op        = op_q;
   assign rd        = rd_q;
   assign rt_addr   = rt_addr_q;
   assign imm_ext   = imm_ext_q;
   assign rs_val    = rs_val_q;
   assign rt_val    = rt_val_q;

   // A stalled bundle must stay valid and unchanged until it is accepted.
   assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable({rs_val_q, rt_val_q, imm_ext_q})));

   // out_valid only appears while the stage is busy.
   assert property (@(posedge clk) disable iff (!rst_n) out_valid_q |-> busy);

endmodule

// File: tb/tb_reg_read.sv
// Bench for reg_read: a register-file model updated on every clock edge
// supplies the expected operand bundle for each read.
module tb_reg_read;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ide;
   logic [31:0] instr;
   logic        wb_update;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rt_addr;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] imm_ext;

   logic [31:0]  model [32];
   logic [111:0] exp_q [$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit rand_wb = 1'b0;

   reg_read dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ide       (ide),
      .instr     (instr),
      .wb_update (wb_update),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op        (op),
      .rd        (rd),
      .rt_addr   (rt_addr),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .imm_ext   (imm_ext)
   );

   // Clock
   always #5 clk = ~clk;

   // One clock: optional random write-back traffic, model update at the edge, settle.
   task automatic step();
      logic        do_wr;
      logic [4:0]  a;
      logic [31:0] d;
      if (rand_wb) begin
         wb_update = 1'($urandom_range(0, 1));
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
      end
      do_wr = rst_n && wb_update;
      a = wb_addr;
      d = wb_data;
      @(posedge clk);
      if (do_wr && a != 5'd0) model[a] = d;
      cyc++;
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wb_update = 1'b1;
      wb_addr   = a;
      wb_data   = d;
      step();
      wb_update = 1'b0;
   endtask

   task automatic hs();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // Expected bundle from the instruction fields and the current register contents.
   function automatic logic [111:0] expect_bundle(input logic [31:0] ins);
      logic [31:0] imm;
      logic [4:0]  s, t;
      s = ins[25:21];
      t = ins[20:16];
      imm = ins[15] ? (32'(ins[15:0]) - 32'h0001_0000) : 32'(ins[15:0]);
      return {ins[31:26], ins[15:11], t, model[s], model[t], imm};
   endfunction

   function automatic logic [111:0] obs();
      return {op, rd, rt_addr, rs_val, rt_val, imm_ext};
   endfunction

   // Issue one read; optionally write-back in the cycle that samples the file.
   task automatic do_read(input logic [31:0] ins, input bit wb_in_rd, input logic [4:0] a,
                          input logic [31:0] d, output logic ov_early, output logic ov_rd,
                          output logic [111:0] exp_b);
      ide   = 1'b1;
      instr = ins;
      step();
      ide   = 1'b0;
      instr = $urandom;
      ov_early = out_valid;
      step();
      ov_early = ov_early | out_valid;
      if (wb_in_rd) begin
         wb_update = 1'b1;
         wb_addr   = a;
         wb_data   = d;
      end
      step();
      if (wb_in_rd) wb_update = 1'b0;
      ov_rd = out_valid;
      exp_b = expect_bundle(ins);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ide = 1'b0; instr = '0; wb_update = 1'b0; wb_addr = '0;
      wb_data = '0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      step();
      step();
      vectors++;
      if ({busy, out_valid, obs()} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h exp 0", {busy, out_valid, obs()});
      end
      rst_n = 1'b1;
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy got %b exp 0", busy);
      end
   endtask

   task automatic test_basic();
      logic ove, ovr;
      logic [111:0] eb;
      wr(5'd5, 32'h2343_9870);
      do_read(32'h00A6_3820, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if (ove !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_early_valid: got %b exp 0", ove);
      end
      vectors++;
      if (ovr !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_latency: out_valid got %b exp 1", ovr);
      end
      vectors++;
      if (obs() !== eb) begin
         miscompares++;
         $display("FAIL basic_bundle: got %h exp %h", obs(), eb);
      end
      vectors++;
      if ({op, rd, rs_val, rt_val} !== {6'd0, 5'd7, 32'h2343_9870, 32'd0}) begin
         miscompares++;
         $display("FAIL basic_fields: got %h exp %h", {op, rd, rs_val, rt_val},
                  {6'd0, 5'd7, 32'h2343_9870, 32'd0});
      end
      hs();
      vectors++;
      if ({busy, out_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL basic_idle: busy/valid got %b exp 00", {busy, out_valid});
      end
   endtask

   task automatic test_imm();
      logic ove, ovr;
      logic [111:0] eb;
      do_read(32'h8C22_FFFC, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if ({imm_ext, op, rt_addr} !== {32'hFFFF_FFFC, 6'h23, 5'd2}) begin
         miscompares++;
         $display("FAIL imm_fields: got %h exp %h", {imm_ext, op, rt_addr},
                  {32'hFFFF_FFFC, 6'h23, 5'd2});
      end
      vectors++;
      if (obs() !== eb) begin
         miscompares++;
         $display("FAIL imm_bundle: got %h exp %h", obs(), eb);
      end
      hs();
   endtask

   task automatic test_r0_bypass();
      logic ove, ovr;
      logic [111:0] eb;
      wr(5'd0, 32'hDEAD_BEEF);
      do_read({6'd0, 5'd0, 5'd0, 16'h0000}, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if (rs_val !== 32'd0) begin
         miscompares++;
         $display("FAIL r0_read: got %h exp 0", rs_val);
      end
      hs();
      wr(5'd3, 32'hAAAA_0000);
      do_read({6'd0, 5'd3, 5'd3, 16'h0010}, 1'b1, 5'd3, 32'h0000_1111, ove, ovr, eb);
      vectors++;
      if ({rs_val, rt_val} !== {32'h0000_1111, 32'h0000_1111}) begin
         miscompares++;
         $display("FAIL bypass_rs_rt: got %h exp %h", {rs_val, rt_val},
                  {32'h0000_1111, 32'h0000_1111});
      end
      vectors++;
      if (obs() !== eb) begin
         miscompares++;
         $display("FAIL bypass_bundle: got %h exp %h", obs(), eb);
      end
      hs();
      do_read({6'd0, 5'd0, 5'd4, 16'h0000}, 1'b1, 5'd0, 32'h0000_FFFF, ove, ovr, eb);
      vectors++;
      if (rs_val !== 32'd0) begin
         miscompares++;
         $display("FAIL bypass_r0: got %h exp 0", rs_val);
      end
      hs();
   endtask

   task automatic test_stall();
      logic ove, ovr;
      logic [111:0] eb;
      logic [31:0] ins;
      ins = {6'h08, 5'd5, 5'd5, 16'h8001};
      wr(5'd5, 32'h0BAD_F00D);
      do_read(ins, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            wb_update = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_5555;
         end
         if (i == 2) begin
            ide = 1'b1; instr = $urandom;
         end
         step();
         wb_update = 1'b0;
         ide = 1'b0;
         vectors++;
         if ({out_valid, obs()} !== {1'b1, eb}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got %h exp %h", i, {out_valid, obs()}, {1'b1, eb});
         end
      end
      hs();
      vectors++;
      if ({busy, out_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL stall_release: busy/valid got %b exp 00", {busy, out_valid});
      end
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ide_ignored: busy got %b exp 0", busy);
      end
      do_read(ins, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if ({rs_val, rt_val} !== {32'h0000_5555, 32'h0000_5555}) begin
         miscompares++;
         $display("FAIL stall_wb_landed: got %h exp %h", {rs_val, rt_val},
                  {32'h0000_5555, 32'h0000_5555});
      end
      hs();
   endtask

   task automatic test_async_reset();
      logic ove, ovr;
      logic [111:0] eb;
      logic [31:0] ins;
      ins = 32'hFC43_7ABC;
      wr(5'd2, 32'h1234_5678);
      ide = 1'b1; instr = ins;
      step();
      ide = 1'b0;
      step();
      vectors++;
      if ({busy, op} !== {1'b1, 6'h3F}) begin
         miscompares++;
         $display("FAIL rd_decoded: got %h exp %h", {busy, op}, {1'b1, 6'h3F});
      end
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      #1;
      vectors++;
      if ({busy, out_valid, obs()} !== '0) begin
         miscompares++;
         $display("FAIL async_reset_outputs: got %h exp 0", {busy, out_valid, obs()});
      end
      ide = 1'b1; instr = ins;
      wb_update = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_CAFE;
      step();
      step();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ide_ignored: busy got %b exp 0", busy);
      end
      rst_n = 1'b1; ide = 1'b0; wb_update = 1'b0;
      step();
      do_read({6'd0, 5'd2, 5'd5, 16'h0000}, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if ({rs_val, rt_val} !== 64'd0 || obs() !== eb) begin
         miscompares++;
         $display("FAIL post_reset_r2_r5: got %h exp %h", obs(), eb);
      end
      hs();
      do_read({6'd0, 5'd3, 5'd9, 16'h0000}, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
      vectors++;
      if ({rs_val, rt_val} !== 64'd0 || obs() !== eb) begin
         miscompares++;
         $display("FAIL post_reset_r3_r9: got %h exp %h", obs(), eb);
      end
      hs();
   endtask

   task automatic test_back_to_back();
      logic ove, ovr;
      logic [111:0] eb;
      logic [111:0] got;
      logic [31:0] ins;
      int rise [4];
      int hs_cnt;
      hs_cnt = 0;
      rand_wb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ins = $urandom;
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         do_read(ins, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
         exp_q.push_back(eb);
         rise[k] = cyc;
         got = obs();
         if (out_valid === 1'b1) hs_cnt++;
         hs();
         vectors++;
         if (got !== exp_q.pop_front()) begin
            miscompares++;
            $display("FAIL b2b_bundle[%0d]: got %h exp %h", k, got, eb);
         end
      end
      rand_wb = 1'b0;
      wb_update = 1'b0;
      vectors++;
      if (hs_cnt !== 4) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d exp 4", hs_cnt);
      end
      for (int k = 1; k < 4; k++) begin
         vectors++;
         if (rise[k] - rise[k-1] !== 4) begin
            miscompares++;
            $display("FAIL b2b_interval[%0d]: got %0d exp 4", k, rise[k] - rise[k-1]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         step();
         vectors++;
         if ({busy, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_no_extra[%0d]: got %b exp 00", k, {busy, out_valid});
         end
      end
   endtask

   task automatic test_random();
      logic ove, ovr;
      logic [111:0] eb;
      logic [31:0] ins;
      int dly;
      rand_wb = 1'b1;
      for (int k = 0; k < 20; k++) begin
         ins = $urandom;
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         do_read(ins, 1'b0, 5'd0, 32'd0, ove, ovr, eb);
         dly = $urandom_range(0, 3);
         for (int j = 0; j < dly; j++) step();
         vectors++;
         if ({ove, out_valid, obs()} !== {1'b0, 1'b1, eb}) begin
            miscompares++;
            $display("FAIL rand_bundle[%0d]: got %h exp %h", k, {ove, out_valid, obs()},
                     {1'b0, 1'b1, eb});
         end
         hs();
      end
      rand_wb = 1'b0;
      wb_update = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_imm();
      test_r0_bypass();
      test_stall();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
